// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA scheduler.
// Optional feature macro: DMA_CH_PRIORITY_EN (per-channel 2-bit priority).
package dma_pkg;

    // Beat width of a transfer as seen by the engine
    typedef enum logic [1:0] {
        TW_BYTE  = 2'd0,
        TW_HALF  = 2'd1,
        TW_WORD  = 2'd2,
        TW_DWORD = 2'd3
    } transfer_width_e;

    // Word offsets inside a channel's register window
    localparam logic [1:0] WORD_SRC  = 2'd0;
    localparam logic [1:0] WORD_DST  = 2'd1;
    localparam logic [1:0] WORD_LEN  = 2'd2;
    localparam logic [1:0] WORD_CTRL = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_START    = 0;
    localparam int CTRL_SRC_INC  = 1;
    localparam int CTRL_DST_INC  = 2;
    localparam int CTRL_INT_EN   = 3;
    localparam int CTRL_BURST_EN = 4;
    localparam int CTRL_WIDTH_LO = 5;
    localparam int CTRL_WIDTH_HI = 6;
    localparam int CTRL_ABORT    = 7;
    localparam int CTRL_ACTIVE   = 8;
    localparam int CTRL_DONE     = 9;
    localparam int CTRL_ERROR    = 10;
    localparam int CTRL_PRIO_LO  = 12;
    localparam int CTRL_PRIO_HI  = 13;

    // Scheduler FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } dma_state_e;

    // Per-channel mode bits (prio stays 0 unless priority is compiled in)
    typedef struct packed {
        logic [1:0]      prio;
        transfer_width_e width;
        logic            burst_en;
        logic            int_en;
        logic            dst_inc;
        logic            src_inc;
    } ch_mode_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter with rotating start pointer and priority masking.
// Requests below the highest pending priority are masked before the
// rotating search, so equal priorities share the round-robin order.
module dma_rr_arbiter
    import dma_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      i_req,
    input  logic [NUM_CH-1:0][1:0] i_prio,
    input  logic                   i_update,
    output logic                   o_valid,
    output logic [CH_W-1:0]        o_idx
);

    logic [CH_W-1:0]   r_ptr;
    logic [1:0]        w_max;
    logic [NUM_CH-1:0] w_req_m;

    // Keep only requests at the highest pending priority
    always_comb begin
        w_max   = '0;
        w_req_m = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (i_req[i] && (i_prio[i] > w_max)) w_max = i_prio[i];
        for (int i = 0; i < NUM_CH; i++)
            w_req_m[i] = i_req[i] && (i_prio[i] == w_max);
    end

    // First masked request found searching upward from the pointer
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int              j;
            logic [CH_W-1:0] w_k;
            j = int'(r_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            w_k = CH_W'(j);
            if (!o_valid && w_req_m[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end

    // Pointer moves to the channel after the one just granted
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (i_update && o_valid)
            r_ptr <= (int'(o_idx) == NUM_CH - 1) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/dma_mc_scheduler.sv
// Multi-channel DMA scheduler: CPU register file per channel, round-robin
// arbitration, and a single shared transfer engine launched one channel
// at a time. Optional macro: DMA_CH_PRIORITY_EN enables CTRL[13:12]
// as a per-channel priority.
module dma_mc_scheduler
    import dma_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 32,
    parameter  int LEN_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic              reg_read,
    input  logic [CH_W+1:0]   reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_src_addr,
    output logic [ADDR_W-1:0] eng_dst_addr,
    output logic [LEN_W-1:0]  eng_length,
    output logic              eng_src_inc,
    output logic              eng_dst_inc,
    output logic              eng_burst_en,
    output logic [1:0]        eng_width,
    output logic [CH_W-1:0]   eng_ch,
    input  logic              eng_done,
    input  logic              eng_error,
    output logic              interrupt
);

    logic [NUM_CH-1:0][ADDR_W-1:0] r_src, r_dst;
    logic [NUM_CH-1:0][LEN_W-1:0]  r_len;
    ch_mode_t [NUM_CH-1:0]         r_mode;
    logic [NUM_CH-1:0]             r_pend, r_act, r_done, r_err;
    dma_state_e                    r_state, w_state_nxt;
    logic [CH_W-1:0]               r_ch;
    logic [31:0]                   r_rdata;
    logic                          r_irq;

    logic [CH_W-1:0]               w_ch;
    logic [1:0]                    w_word;
    logic                          w_ch_ok;
    logic [NUM_CH-1:0]             w_wsel;
    logic [NUM_CH-1:0][1:0]        w_prio;
    logic                          w_arb_valid;
    logic [CH_W-1:0]               w_arb_idx;
    logic                          w_grant, w_fin;
    logic [31:0]                   w_rd_val;
    logic [NUM_CH-1:0]             w_irq_vec;

    assign w_ch    = reg_addr[CH_W+1:2];
    assign w_word  = reg_addr[1:0];
    assign w_ch_ok = int'(w_ch) < NUM_CH;

    // Per-channel write select and arbiter inputs
    always_comb begin
        w_wsel    = '0;
        w_prio    = '0;
        w_irq_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wsel[c]    = reg_write && w_ch_ok && (int'(w_ch) == c);
            w_prio[c]    = r_mode[c].prio;
            w_irq_vec[c] = r_mode[c].int_en && (r_done[c] || r_err[c]);
        end
    end

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (r_pend),
        .i_prio   (w_prio),
        .i_update (w_grant),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx)
    );

    // FSM state register and latched grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_ch <= w_arb_idx;
        end
    end

    // FSM next state, launch pulse and completion detect
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fin       = 1'b0;
        eng_start   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                eng_start   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done || eng_error) begin
                    w_fin       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Engine parameters follow the granted channel while a transfer is out;
    // the channel's registers are write-locked then, so they stay stable
    always_comb begin
        eng_src_addr = '0;
        eng_dst_addr = '0;
        eng_length   = '0;
        eng_src_inc  = 1'b0;
        eng_dst_inc  = 1'b0;
        eng_burst_en = 1'b0;
        eng_width    = 2'b00;
        eng_ch       = '0;
        if (r_state != ST_IDLE) begin
            eng_src_addr = r_src[r_ch];
            eng_dst_addr = r_dst[r_ch];
            eng_length   = r_len[r_ch];
            eng_src_inc  = r_mode[r_ch].src_inc;
            eng_dst_inc  = r_mode[r_ch].dst_inc;
            eng_burst_en = r_mode[r_ch].burst_en;
            eng_width    = r_mode[r_ch].width;
            eng_ch       = r_ch;
        end
    end

    // Channel register file, pending/active tracking and status bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_act  <= '0;
            r_done <= '0;
            r_err  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic busy, ctrl_wr, start_ok, mine_fin;
                busy     = r_pend[c] || r_act[c];
                ctrl_wr  = w_wsel[c] && (w_word == WORD_CTRL);
                start_ok = ctrl_wr && reg_wdata[CTRL_START] && !busy;
                mine_fin = w_fin && (int'(r_ch) == c);

                if (w_wsel[c] && !busy) begin
                    case (w_word)
                        WORD_SRC: r_src[c] <= reg_wdata[ADDR_W-1:0];
                        WORD_DST: r_dst[c] <= reg_wdata[ADDR_W-1:0];
                        WORD_LEN: r_len[c] <= reg_wdata[LEN_W-1:0];
                        default: begin
                            r_mode[c].src_inc  <= reg_wdata[CTRL_SRC_INC];
                            r_mode[c].dst_inc  <= reg_wdata[CTRL_DST_INC];
                            r_mode[c].int_en   <= reg_wdata[CTRL_INT_EN];
                            r_mode[c].burst_en <= reg_wdata[CTRL_BURST_EN];
                            r_mode[c].width    <= transfer_width_e'(reg_wdata[CTRL_WIDTH_HI:CTRL_WIDTH_LO]);
`ifdef DMA_CH_PRIORITY_EN
                            r_mode[c].prio     <= reg_wdata[CTRL_PRIO_HI:CTRL_PRIO_LO];
`else
                            r_mode[c].prio     <= 2'b00;
`endif
                        end
                    endcase
                end

                // Zero-length start completes immediately without a launch
                if (start_ok && (r_len[c] != '0)) r_pend[c] <= 1'b1;
                if ((ctrl_wr && reg_wdata[CTRL_ABORT]) ||
                    (w_grant && (int'(w_arb_idx) == c)))
                    r_pend[c] <= 1'b0;

                if (w_grant && (int'(w_arb_idx) == c)) r_act[c] <= 1'b1;
                if (mine_fin) r_act[c] <= 1'b0;

                // Hardware set is evaluated last so it beats a same-cycle W1C
                if (ctrl_wr && reg_wdata[CTRL_DONE])  r_done[c] <= 1'b0;
                if (ctrl_wr && reg_wdata[CTRL_ERROR]) r_err[c]  <= 1'b0;
                if ((mine_fin && eng_done && !eng_error) ||
                    (start_ok && (r_len[c] == '0)))
                    r_done[c] <= 1'b1;
                if (mine_fin && eng_error) r_err[c] <= 1'b1;
            end
        end
    end

    // Read mux for the addressed word
    always_comb begin
        w_rd_val = '0;
        if (w_ch_ok) begin
            case (w_word)
                WORD_SRC: w_rd_val = 32'(r_src[w_ch]);
                WORD_DST: w_rd_val = 32'(r_dst[w_ch]);
                WORD_LEN: w_rd_val = 32'(r_len[w_ch]);
                default: begin
                    w_rd_val[CTRL_START]                  = r_pend[w_ch];
                    w_rd_val[CTRL_SRC_INC]                = r_mode[w_ch].src_inc;
                    w_rd_val[CTRL_DST_INC]                = r_mode[w_ch].dst_inc;
                    w_rd_val[CTRL_INT_EN]                 = r_mode[w_ch].int_en;
                    w_rd_val[CTRL_BURST_EN]               = r_mode[w_ch].burst_en;
                    w_rd_val[CTRL_WIDTH_HI:CTRL_WIDTH_LO] = r_mode[w_ch].width;
                    w_rd_val[CTRL_ACTIVE]                 = r_act[w_ch];
                    w_rd_val[CTRL_DONE]                   = r_done[w_ch];
                    w_rd_val[CTRL_ERROR]                  = r_err[w_ch];
                    w_rd_val[CTRL_PRIO_HI:CTRL_PRIO_LO]   = r_mode[w_ch].prio;
                end
            endcase
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_rdata <= reg_read ? w_rd_val : '0;
            r_irq   <= |w_irq_vec;
        end
    end

    assign reg_rdata = r_rdata;
    assign interrupt = r_irq;

endmodule

// File: tb/tb_dma_mc_scheduler.sv
// Self-checking bench for dma_mc_scheduler: register table, directed
// multi-cycle sequences, and randomized rounds against a set-based model.
module tb_dma_mc_scheduler;

    localparam int N = 4;
`ifdef DMA_CH_PRIORITY_EN
    localparam logic [31:0] PRIO_RB = 32'h3000;
`else
    localparam logic [31:0] PRIO_RB = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst, reg_write, reg_read;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        eng_start, eng_src_inc, eng_dst_inc, eng_burst_en;
    logic [31:0] eng_src_addr, eng_dst_addr;
    logic [15:0] eng_length;
    logic [1:0]  eng_width, eng_ch;
    logic        eng_done, eng_error, interrupt;

    always #5 clk = ~clk;

    dma_mc_scheduler #(.NUM_CH(N), .ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .reg_read(reg_read),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .eng_start(eng_start), .eng_src_addr(eng_src_addr), .eng_dst_addr(eng_dst_addr),
        .eng_length(eng_length), .eng_src_inc(eng_src_inc), .eng_dst_inc(eng_dst_inc),
        .eng_burst_en(eng_burst_en), .eng_width(eng_width), .eng_ch(eng_ch),
        .eng_done(eng_done), .eng_error(eng_error), .interrupt(interrupt)
    );

    int checks = 0, errors = 0;
    int start_cnt = 0;
    int last_ch = 0;
    bit auto_en = 0, rand_kind = 0, hold = 0;
    int gq[$], kq[$];
    logic [31:0] sq[$], dq[$];
    logic [15:0] lq[$];

    typedef struct {
        string       name;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic logic [3:0] A(input int ch, input int w);
        return {ch[1:0], w[1:0]};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_write = 1'b1;
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        reg_addr = a; reg_read = 1'b1;
        @(posedge clk); #1;
        reg_read = 1'b0;
        d = reg_rdata;
    endtask

    task automatic rdchk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(nm, v, exp);
    endtask

    task automatic wait_starts(input int target, input string nm);
        int t = 0;
        while (start_cnt < target && t < 200) begin @(negedge clk); #1; t++; end
        if (start_cnt < target) tmo(nm);
    endtask

    task automatic wait_q(input int n, input string nm);
        int t = 0;
        while ((gq.size() < n || kq.size() < n) && t < 2000) begin @(negedge clk); #1; t++; end
        if (gq.size() < n || kq.size() < n) tmo(nm);
    endtask

    task automatic pulse(input logic d, input logic e);
        @(negedge clk); eng_done = d; eng_error = e;
        @(negedge clk); eng_done = 1'b0; eng_error = 1'b0;
    endtask

    task automatic qclear();
        gq.delete(); kq.delete(); sq.delete(); dq.delete(); lq.delete();
    endtask

    // Launch monitor
    always @(negedge clk) if (eng_start === 1'b1) begin
        start_cnt++;
        last_ch = int'(eng_ch);
    end

    // Engine responder used in automatic mode
    initial begin
        eng_done = 1'b0; eng_error = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en && eng_start === 1'b1) begin
                int c, k, n;
                logic [31:0] s, d;
                logic [15:0] l;
                c = int'(eng_ch); s = eng_src_addr; d = eng_dst_addr; l = eng_length;
                gq.push_back(c); sq.push_back(s); dq.push_back(d); lq.push_back(l);
                repeat (1 + $urandom_range(0, 3)) @(negedge clk);
                n = 0;
                while (hold && n < 2000) begin @(negedge clk); n++; end
                if (n >= 2000) tmo("resp_hold");
                chk("stable_src", eng_src_addr, s);
                chk("stable_len", 32'(eng_length), 32'(l));
                chk("stable_ch", 32'(eng_ch), 32'(c));
                k = rand_kind ? int'($urandom_range(0, 2)) : 0;
                kq.push_back(k);
                eng_done = (k != 1); eng_error = (k != 0);
                @(negedge clk);
                eng_done = 1'b0; eng_error = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int cnt0;
        int exp_order[$];
        logic [31:0] msrc[N], mdst[N];
        logic [15:0] mlen[N];
        bit mie[N], mdone[N], merr[N], in_s[N];

        rst = 1'b1; reg_write = 1'b0; reg_read = 1'b0; reg_addr = '0; reg_wdata = '0;
        tbl[0] = '{"rw_src0",  A(0,0), 32'hDEADBEEF, A(0,0), 32'hDEADBEEF};
        tbl[1] = '{"rw_dst1",  A(1,1), 32'h12345678, A(1,1), 32'h12345678};
        tbl[2] = '{"rw_len2",  A(2,2), 32'hABCD1234, A(2,2), 32'h00001234};
        tbl[3] = '{"rw_ctrl3", A(3,3), 32'h000037FE, A(3,3), 32'h0000007E | PRIO_RB};
        tbl[4] = '{"clr_ctrl3",A(3,3), 32'h00000000, A(3,3), 32'h00000000};
        tbl[5] = '{"width2",   A(2,3), 32'h00000060, A(2,3), 32'h00000060};
        tbl[6] = '{"isolate",  A(0,0), 32'h00000000, A(1,1), 32'h12345678};
        tbl[7] = '{"clr_ctrl2",A(2,3), 32'h00000000, A(2,3), 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_irq", 32'(interrupt), 0);
        chk("rst_rdata", reg_rdata, 0);
        chk("rst_eng_src", eng_src_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) rdchk("rst_ctrl", A(c,3), 0);

        // Register table
        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rdchk(tbl[i].name, tbl[i].raddr, tbl[i].exp);
        end

        // Basic transfer latency and completion
        wr(A(1,0), 32'h1000); wr(A(1,1), 32'h2000); wr(A(1,2), 8);
        wr(A(1,3), 32'h0000000B);
        @(negedge clk); chk("lat_cyc2_nostart", 32'(eng_start), 0);
        @(negedge clk);
        chk("lat_cyc3_start", 32'(eng_start), 1);
        chk("lat_ch", 32'(eng_ch), 1);
        chk("lat_len", 32'(eng_length), 8);
        chk("lat_src", eng_src_addr, 32'h1000);
        chk("lat_dst", eng_dst_addr, 32'h2000);
        chk("lat_src_inc", 32'(eng_src_inc), 1);
        @(negedge clk); chk("start_one_cycle", 32'(eng_start), 0);
        eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        rdchk("ch1_done", A(1,3), 32'h20A);
        chk("ch1_irq", 32'(interrupt), 1);

        // Round-robin order with a restart
        for (int c = 0; c < N; c++) begin wr(A(c,3), 32'h600); wr(A(c,2), 4); end
        qclear(); auto_en = 1; rand_kind = 0; hold = 0;
        for (int c = 0; c < N; c++) wr(A(c,3), 32'h1);
        wait_q(2, "rr_first2");
        wr(A(0,3), 32'h1);
        wait_q(5, "rr_all5");
        repeat (10) @(negedge clk);
        chk("rr_count", gq.size(), 5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], exp_order[i]);

        // Zero-length start
        wr(A(2,3), 32'h600); wr(A(2,2), 0);
        cnt0 = start_cnt;
        wr(A(2,3), 32'h9);
        repeat (6) @(negedge clk);
        chk("len0_no_start", start_cnt, cnt0);
        rdchk("len0_done", A(2,3), 32'h208);

        // Simultaneous done+error, and hardware set vs W1C
        auto_en = 0;
        wr(A(1,3), 32'h600); wr(A(1,2), 5);
        cnt0 = start_cnt; wr(A(1,3), 32'h1);
        wait_starts(cnt0 + 1, "both_start");
        pulse(1'b1, 1'b1);
        rdchk("both_err_only", A(1,3), 32'h400);
        cnt0 = start_cnt; wr(A(1,3), 32'h1);
        wait_starts(cnt0 + 1, "w1c_start");
        @(negedge clk);
        eng_error = 1'b1; reg_addr = A(1,3); reg_wdata = 32'h400; reg_write = 1'b1;
        @(negedge clk);
        eng_error = 1'b0; reg_write = 1'b0;
        rdchk("hw_set_wins", A(1,3), 32'h400);
        wr(A(1,3), 32'h400);
        rdchk("w1c_clears", A(1,3), 32'h0);

        // Abort on pending channel, locked registers while active
        wr(A(3,3), 32'h600); wr(A(3,2), 3); wr(A(1,0), 32'h1111);
        cnt0 = start_cnt; wr(A(1,3), 32'h1);
        wait_starts(cnt0 + 1, "abort_start");
        wr(A(3,3), 32'h1);
        rdchk("ch3_pending", A(3,3), 32'h1);
        wr(A(3,3), 32'h80);
        rdchk("ch3_aborted", A(3,3), 32'h0);
        wr(A(1,0), 32'hFFFF0000);
        rdchk("src_locked", A(1,0), 32'h1111);
        rdchk("ch1_active", A(1,3), 32'h100);
        pulse(1'b1, 1'b0);
        cnt0 = start_cnt;
        repeat (10) @(negedge clk);
        chk("ch3_never_granted", start_cnt, cnt0);
        rdchk("ch1_done_after", A(1,3), 32'h200);

`ifdef DMA_CH_PRIORITY_EN
        // Priority beats round-robin position
        for (int c = 0; c < N; c++) begin wr(A(c,3), 32'h600); wr(A(c,2), 2); end
        cnt0 = start_cnt; wr(A(3,3), 32'h1);
        wait_starts(cnt0 + 1, "prio_hold");
        wr(A(0,3), 32'h0001); wr(A(2,3), 32'h3001);
        pulse(1'b1, 1'b0);
        wait_starts(cnt0 + 2, "prio_g1");
        chk("prio_first_ch2", last_ch, 2);
        pulse(1'b1, 1'b0);
        wait_starts(cnt0 + 3, "prio_g2");
        chk("prio_then_ch0", last_ch, 0);
        pulse(1'b1, 1'b0);
`endif

        // Reset during WAIT abandons the transfer
        wr(A(1,2), 5);
        cnt0 = start_cnt; wr(A(1,3), 32'h9);
        wait_starts(cnt0 + 1, "rstw_start");
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        #1;
        chk("rstw_eng_start", 32'(eng_start), 0);
        chk("rstw_eng_ch", 32'(eng_ch), 0);
        chk("rstw_irq", 32'(interrupt), 0);
        for (int c = 0; c < N; c++) rdchk("rstw_ctrl", A(c,3), 0);
        rdchk("rstw_src1", A(1,0), 0);
        cnt0 = start_cnt;
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("rstw_no_launch", start_cnt, cnt0);
        rdchk("rstw_done_ignored", A(1,3), 0);

        // Randomized rounds against a set-based model
        auto_en = 1; rand_kind = 1;
        for (int r = 0; r < 20; r++) begin
            int x;
            int last;
            bit any, irq_exp;
            for (int c = 0; c < N; c++) begin
                msrc[c] = $urandom; mdst[c] = $urandom;
                mlen[c] = 16'($urandom_range(1, 65535));
                mie[c] = 1'($urandom_range(0, 1));
                mdone[c] = 0; merr[c] = 0; in_s[c] = 0;
                wr(A(c,0), msrc[c]); wr(A(c,1), mdst[c]); wr(A(c,2), 32'(mlen[c]));
                wr(A(c,3), 32'h600 | (32'(mie[c]) << 3));
            end
            qclear(); hold = 1;
            x = int'($urandom_range(0, N-1));
            wr(A(x,3), 32'h1 | (32'(mie[x]) << 3));
            wait_q(0, "rnd_dummy");
            begin
                int t = 0;
                while (gq.size() < 1 && t < 200) begin @(negedge clk); #1; t++; end
                if (gq.size() < 1) tmo("rnd_first");
            end
            for (int c = 0; c < N; c++) if (c != x && $urandom_range(0, 1) == 1) begin
                in_s[c] = 1;
                wr(A(c,3), 32'h1 | (32'(mie[c]) << 3));
            end
            for (int c = 0; c < N; c++) if (in_s[c] && $urandom_range(0, 3) == 0) begin
                in_s[c] = 0;
                wr(A(c,3), 32'h80);
            end
            hold = 0;
            exp_order.delete();
            exp_order.push_back(x);
            last = x;
            do begin
                any = 0;
                for (int k = 1; k <= N && !any; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (in_s[c]) begin
                        in_s[c] = 0; any = 1; last = c; exp_order.push_back(c);
                    end
                end
            end while (any);
            wait_q(exp_order.size(), "rnd_grants");
            repeat (8) @(negedge clk);
            chk("rnd_count", gq.size(), exp_order.size());
            for (int i = 0; i < exp_order.size() && i < gq.size() && i < kq.size(); i++) begin
                int c;
                c = exp_order[i];
                chk("rnd_order", gq[i], c);
                chk("rnd_src", sq[i], msrc[c]);
                chk("rnd_dst", dq[i], mdst[c]);
                chk("rnd_len", 32'(lq[i]), 32'(mlen[c]));
                if (kq[i] == 0) mdone[c] = 1; else merr[c] = 1;
            end
            irq_exp = 0;
            for (int c = 0; c < N; c++) begin
                rdchk("rnd_ctrl", A(c,3),
                      (32'(mie[c]) << 3) | (32'(mdone[c]) << 9) | (32'(merr[c]) << 10));
                if (mie[c] && (mdone[c] || merr[c])) irq_exp = 1;
            end
            chk("rnd_irq", 32'(interrupt), 32'(irq_exp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_mc_scheduler.md
DMA_MC_SCHEDULER -- requirements
Module: dma_mc_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, source and destination address width.
REQ-003 SHALL have parameter LEN_W, default 16, transfer length width in beats.
REQ-004 SHALL derive CH_W = $clog2(NUM_CH) and have port clk  in  1  the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports reg_write, reg_read  in  1 each  CPU register strobes.
REQ-007 SHALL have port reg_addr  in  CH_W+2  address: [CH_W+1:2] selects the channel, [1:0] selects the word.
REQ-008 SHALL have ports reg_wdata  in  32 and reg_rdata  out  32  CPU register data.
REQ-009 SHALL have port eng_start  out  1  single-cycle launch pulse to the shared transfer engine.
REQ-010 SHALL have ports eng_src_addr, eng_dst_addr  out  ADDR_W and eng_length  out  LEN_W  parameters of the granted channel.
REQ-011 SHALL have ports eng_src_inc, eng_dst_inc, eng_burst_en  out  1 and eng_width  out  2  granted channel mode.
REQ-012 SHALL have port eng_ch  out  CH_W  granted channel index.
REQ-013 SHALL have ports eng_done, eng_error  in  1  single-cycle completion pulses from the engine.
REQ-014 SHALL have port interrupt  out  1  aggregated channel interrupt.

Function
REQ-015 SHALL map each channel's words as: 0 SRC, 1 DST, 2 LEN (bits [LEN_W-1:0]), 3 CTRL.
REQ-016 SHALL define CTRL bits as follows: 0 start (W1, reads pending), 1 src_inc, 2 dst_inc, 3 int_en, 4 burst_en, 6:5 width, 7 abort (W1, reads 0), 8 active (RO), 9 done (W1C), 10 error (W1C).
REQ-017 SHALL return reg_rdata registered, valid the cycle after reg_read; unaddressed or unused bits read 0.
REQ-018 SHALL read channel indices >= NUM_CH as 0 and ignore writes to them.
REQ-019 SHALL ignore writes to SRC/DST/LEN and to CTRL mode bits while that channel is pending or active.
REQ-020 SHALL ignore start=1 on a pending or active channel.
REQ-021 SHALL, on start=1 with LEN=0, set done without setting pending and without any engine launch.
REQ-022 SHALL use FSM states IDLE, LAUNCH, WAIT.
REQ-023 SHALL, in IDLE with any channel pending, register the arbiter grant, set that channel active, clear its pending, and go to LAUNCH.
REQ-024 SHALL, in LAUNCH, assert eng_start for exactly one cycle and then go to WAIT.
REQ-025 SHALL hold all eng_* parameter outputs stable from LAUNCH until WAIT exits, and drive them 0 otherwise.
REQ-026 SHALL, in WAIT on eng_done, set done; on eng_error, set error; on both in the same cycle, set error only; in every case clear active and go to IDLE.
REQ-027 SHALL ignore eng_done and eng_error outside WAIT.
REQ-028 SHALL arbitrate round-robin: search starts at (last granted + 1) mod NUM_CH; the pointer updates on grant.
REQ-029 SHALL, on abort, clear pending only; an active transfer runs to completion.
REQ-030 SHALL let a hardware set of done/error win over a same-cycle W1C clear.
REQ-031 SHALL drive interrupt = OR over channels of int_en & (done | error), registered.
REQ-032 SHALL take a minimum of 3 cycles from a start write to eng_start: write, IDLE grant, LAUNCH.

Reset
REQ-033 SHALL, on rst, clear all channel registers, pending, active, done and error, set the FSM to IDLE, set the round-robin pointer to channel 0, and drive all outputs to 0.
REQ-034 SHALL, on rst mid-transfer, abandon the transfer without generating a completion.

Configuration
REQ-035 SHALL, with DMA_CH_PRIORITY_EN defined, add CTRL bits 13:12 as a per-channel priority (3 highest); the grant goes to the highest pending priority, with round-robin among equal priorities.
REQ-036 SHALL, without DMA_CH_PRIORITY_EN, make bits 13:12 read 0 and ignore writes, with pure round-robin arbitration.

Structure
REQ-037 SHALL place transfer_width_e, CTRL bit-position constants and the FSM state enum in dma_pkg.
REQ-038 SHALL implement arbitration in sub-module dma_rr_arbiter (NUM_CH-wide request/grant with rotating pointer, optional priority masking).

Verification
REQ-039 SHALL cover: ch1 SRC=0x1000, DST=0x2000, LEN=8, start -> eng_start on the third cycle with eng_ch=1, eng_length=8; eng_done -> ch1 done=1, interrupt=1 if int_en=1.
REQ-040 SHALL cover: ch0..ch3 all started in one burst of writes -> grant order 0,1,2,3; ch0 restarted during ch1 -> order continues 2,3,0.
REQ-041 SHALL cover: LEN=0 start on ch2 -> done=1 with no eng_start pulse.
REQ-042 SHALL cover: eng_done and eng_error in the same cycle -> error=1, done=0; a W1C write in the same cycle as a hardware set -> the bit stays 1.
REQ-043 SHALL cover: abort on pending ch3 -> ch3 never granted; a write to ch1 SRC while active -> readback unchanged.
REQ-044 SHALL cover, with DMA_CH_PRIORITY_EN: ch0 prio 0, ch2 prio 3, both pending -> ch2 granted first; rst asserted in WAIT -> all CTRL bits read 0.
